// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered RV32I ALU control decoder with optional M-ext sequencing (macro ALUCTRL_MEXT_EN)
module alu_ctrl_seq #(
    parameter int SEL_W   = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [2:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic [SEL_W-1:0] aluselect,
    output logic             valid_out,
    output logic             illegal,
    output logic             md_start,
    output logic             stall
);

`ifdef ALUCTRL_MEXT_EN
    localparam int MIN_SEL_W = 5;
`else
    localparam int MIN_SEL_W = 4;
`endif

    // Reject parameter sets the encoding or the sequencer cannot represent
    generate
        if (SEL_W < MIN_SEL_W) begin : g_bad_sel_w
            $error("alu_ctrl_seq: SEL_W too small for the enabled operation set");
        end
        if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
            $error("alu_ctrl_seq: MUL_LAT and DIV_LAT must be at least 1");
        end
    endgenerate

    localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_SLL  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_SLT  = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_SRL  = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_BEQ  = SEL_W'(8);
    localparam logic [SEL_W-1:0] OP_BNE  = SEL_W'(9);
    localparam logic [SEL_W-1:0] OP_BLT  = SEL_W'(10);
    localparam logic [SEL_W-1:0] OP_BGE  = SEL_W'(11);
    localparam logic [SEL_W-1:0] OP_SRA  = SEL_W'(12);
    localparam logic [SEL_W-1:0] OP_SLTU = SEL_W'(13);
    localparam logic [SEL_W-1:0] OP_BLTU = SEL_W'(14);
    localparam logic [SEL_W-1:0] OP_BGEU = SEL_W'(15);

    logic [SEL_W-1:0] dec_code;
    logic             dec_illegal;
    logic             dec_m;

    // Combinational decode of the format class and function fields
    always_comb begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
        dec_m       = 1'b0;
        case (aluop)
            3'b000: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_code = OP_ADD;
                        3'b001:  dec_code = OP_SLL;
                        3'b010:  dec_code = OP_SLT;
                        3'b011:  dec_code = OP_SLTU;
                        3'b100:  dec_code = OP_XOR;
                        3'b101:  dec_code = OP_SRL;
                        3'b110:  dec_code = OP_OR;
                        default: dec_code = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      dec_code = OP_SUB;
                    else if (funct3 == 3'b101) dec_code = OP_SRA;
                    else                       dec_illegal = 1'b1;
`ifdef ALUCTRL_MEXT_EN
                end else if (funct7 == 7'b0000001) begin
                    dec_code = SEL_W'({2'b10, funct3});
                    dec_m    = 1'b1;
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            3'b001: begin
                case (funct3)
                    3'b000:  dec_code = OP_ADD;
                    3'b001: begin
                        if (funct7 == 7'b0000000) dec_code = OP_SLL;
                        else                      dec_illegal = 1'b1;
                    end
                    3'b010:  dec_code = OP_SLT;
                    3'b011:  dec_code = OP_SLTU;
                    3'b100:  dec_code = OP_XOR;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec_code = OP_SRL;
                        else if (funct7 == 7'b0100000) dec_code = OP_SRA;
                        else                           dec_illegal = 1'b1;
                    end
                    3'b110:  dec_code = OP_OR;
                    default: dec_code = OP_AND;
                endcase
            end
            3'b100: begin
                case (funct3)
                    3'b000:  dec_code = OP_BEQ;
                    3'b001:  dec_code = OP_BNE;
                    3'b100:  dec_code = OP_BLT;
                    3'b101:  dec_code = OP_BGE;
                    3'b110:  dec_code = OP_BLTU;
                    3'b111:  dec_code = OP_BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_code = OP_ADD;
        endcase
        // An illegal instruction still flows down the pipe, but as a harmless ADD
        if (dec_illegal) begin
            dec_code = OP_ADD;
            dec_m    = 1'b0;
        end
    end

`ifdef ALUCTRL_MEXT_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Output registers plus the mul/div latency sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            aluselect <= OP_ADD;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            md_start  <= 1'b0;
            stall     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= '0;
            aluselect <= OP_ADD;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            md_start  <= 1'b0;
            stall     <= 1'b0;
        end else if (state == BUSY) begin
            // The latency count runs freely; only the exit waits for the pipe to advance
            md_start <= 1'b0;
            if (count != '0) begin
                count <= count - 1'b1;
            end else if (enable) begin
                state <= IDLE;
                stall <= 1'b0;
            end
        end else if (enable) begin
            aluselect <= dec_code;
            valid_out <= valid_in;
            illegal   <= valid_in & dec_illegal;
            if (valid_in && dec_m) begin
                state    <= BUSY;
                md_start <= 1'b1;
                stall    <= 1'b1;
                count    <= funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            end
        end
    end
`else
    // Output registers; without the M extension there is nothing to sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluselect <= OP_ADD;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            aluselect <= OP_ADD;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else if (enable) begin
            aluselect <= dec_code;
            valid_out <= valid_in;
            illegal   <= valid_in & dec_illegal;
        end
    end

    assign md_start = 1'b0;
    assign stall    = 1'b0;

    logic unused_dec_m;
    assign unused_dec_m = dec_m;
`endif

endmodule
